// File: rtl/multdiv_issue_ctrl_pkg.sv
// multdiv_issue_ctrl_pkg: shared FSM encodings, exception codes and $rstatus index
package multdiv_issue_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} md_state_e;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam logic [4:0] RSTATUS_REG = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE = 32'd5;
endpackage

// File: rtl/md_timeout_counter.sv
// md_timeout_counter: saturating BUSY-cycle timer flagging expiry at TIMEOUT_CYC-1
module md_timeout_counter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC) + 1;
  logic [W-1:0] count;
  always_ff @(posedge clock) begin
    if (!reset || clear) count <= '0;
    else if (enable && count != '1) count <= count + 1'b1;
  end
  always_comb expired = count == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: issues mult/div start pulses, stalls until ready/timeout, presents writeback
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_Mult_in,
  input  logic        ctrl_Div_in,
  input  logic [4:0]  x_rd,
  input  logic [31:0] x_operandA,
  input  logic [31:0] x_operandB,
  output logic        md_ctrl_Mult,
  output logic        md_ctrl_Div,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);
  md_state_e state, state_nxt;
  logic req, issue, finish, expired, exc, op_div;
  logic [4:0] rd_q;
  md_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(issue),
    .enable(state == BUSY),
    .expired(expired)
  );
  always_comb begin
    req = ctrl_Mult_in | ctrl_Div_in;
    issue = state == IDLE && req;
    finish = state == BUSY && (md_resultRDY || expired);
    exc = md_resultRDY ? md_exception : 1'b1;
    stall = issue || state == BUSY;
    state_nxt = issue ? BUSY : finish ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      md_ctrl_Mult <= 1'b0;
      md_ctrl_Div <= 1'b0;
      md_operandA <= '0;
      md_operandB <= '0;
      op_div <= 1'b0;
      rd_q <= '0;
      wb_valid <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
    end else begin
      md_ctrl_Mult <= issue && ctrl_Mult_in;
      md_ctrl_Div <= issue && !ctrl_Mult_in;
      if (issue) begin
        op_div <= !ctrl_Mult_in;
        rd_q <= x_rd;
        md_operandA <= x_operandA;
        md_operandB <= x_operandB;
      end
      wb_valid <= finish && (exc || rd_q != 5'd0);
      wb_rd <= !finish ? 5'd0 : exc ? RSTATUS_REG : rd_q;
      wb_data <= !finish ? 32'd0 : !exc ? md_result : op_div ? DIV_EXC_CODE : MULT_EXC_CODE;
    end
  end
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl: table-driven directed bench acting as the multdiv unit
module tb_multdiv_issue_ctrl;
  logic clk = 1'b0;
  logic reset, ctrl_Mult_in, ctrl_Div_in, md_exception, md_resultRDY;
  logic [4:0] x_rd, wb_rd;
  logic [31:0] x_operandA, x_operandB, md_result, md_operandA, md_operandB, wb_data;
  logic md_ctrl_Mult, md_ctrl_Div, stall, wb_valid;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic mult, div;
    logic [4:0] rd;
    logic [31:0] a, b;
    int dly;
    logic exc;
    logic [31:0] res;
    int exp_stall, exp_pm, exp_pd;
    logic exp_wbv;
    logic [4:0] exp_rd;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tv [7];
  always #5 clk = ~clk;
  multdiv_issue_ctrl dut (
    .clock(clk), .reset(reset), .ctrl_Mult_in(ctrl_Mult_in), .ctrl_Div_in(ctrl_Div_in),
    .x_rd(x_rd), .x_operandA(x_operandA), .x_operandB(x_operandB),
    .md_ctrl_Mult(md_ctrl_Mult), .md_ctrl_Div(md_ctrl_Div),
    .md_operandA(md_operandA), .md_operandB(md_operandB),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic apply_vec(input int i);
    vec_t v;
    int stall_n, pm, pd, wbv, done_c, hold_bad;
    logic [4:0] wrd;
    logic [31:0] wdat;
    v = tv[i];
    stall_n = 0; pm = 0; pd = 0; wbv = 0; done_c = -1; hold_bad = 0;
    wrd = '0; wdat = '0;
    @(negedge clk);
    ctrl_Mult_in = v.mult; ctrl_Div_in = v.div; x_rd = v.rd;
    x_operandA = v.a; x_operandB = v.b;
    md_result = v.res; md_exception = v.exc; md_resultRDY = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      md_resultRDY = v.dly >= 0 && c == 1 + v.dly;
      #1;
      stall_n += int'(stall);
      pm += int'(md_ctrl_Mult);
      pd += int'(md_ctrl_Div);
      if (c >= 1 && stall && (md_operandA !== v.a || md_operandB !== v.b)) hold_bad++;
      if (wb_valid) begin
        wbv++;
        wrd = wb_rd;
        wdat = wb_data;
      end
      if (c >= 1 && !stall) begin
        done_c = c;
        break;
      end
    end
    md_resultRDY = 1'b0;
    chk($sformatf("v%0d done_cycle", i), done_c, v.exp_stall);
    chk($sformatf("v%0d stall_cycles", i), stall_n, v.exp_stall);
    chk($sformatf("v%0d mult_pulses", i), pm, v.exp_pm);
    chk($sformatf("v%0d div_pulses", i), pd, v.exp_pd);
    chk($sformatf("v%0d wb_count", i), wbv, {31'd0, v.exp_wbv});
    chk($sformatf("v%0d operand_hold_errors", i), hold_bad, 0);
    if (v.exp_wbv) begin
      chk($sformatf("v%0d wb_rd", i), {27'd0, wrd}, {27'd0, v.exp_rd});
      chk($sformatf("v%0d wb_data", i), wdat, v.exp_data);
    end
  endtask
  task automatic idle_check(input string tag);
    @(negedge clk);
    ctrl_Mult_in = 1'b0; ctrl_Div_in = 1'b0; md_resultRDY = 1'b0;
    #1;
    chk({tag, " idle_stall"}, {31'd0, stall}, 0);
    chk({tag, " idle_wb_valid"}, {31'd0, wb_valid}, 0);
    chk({tag, " idle_pulses"}, {30'd0, md_ctrl_Mult, md_ctrl_Div}, 0);
  endtask
  initial begin
    tv[0] = '{1'b1, 1'b0, 5'd5, 32'd7, 32'd6, 3, 1'b0, 32'd42, 5, 1, 0, 1'b1, 5'd5, 32'd42};
    tv[1] = '{1'b0, 1'b1, 5'd7, 32'd9, 32'd0, 2, 1'b1, 32'd0, 4, 0, 1, 1'b1, 5'd30, 32'd5};
    tv[2] = '{1'b1, 1'b0, 5'd3, 32'd3, 32'd4, -1, 1'b0, 32'd12, 65, 1, 0, 1'b1, 5'd30, 32'd4};
    tv[3] = '{1'b1, 1'b1, 5'd0, 32'd5, 32'd5, 1, 1'b0, 32'd25, 3, 1, 0, 1'b0, 5'd0, 32'd0};
    tv[4] = '{1'b0, 1'b1, 5'd12, 32'd100, 32'd7, 0, 1'b0, 32'd14, 2, 0, 1, 1'b1, 5'd12, 32'd14};
    tv[5] = '{1'b1, 1'b0, 5'd9, 32'h7fffffff, 32'd2, 5, 1'b1, 32'd0, 7, 1, 0, 1'b1, 5'd30, 32'd4};
    tv[6] = '{1'b0, 1'b1, 5'd31, 32'hfffffffc, 32'd2, 1, 1'b0, 32'hfffffffe, 3, 0, 1, 1'b1, 5'd31, 32'hfffffffe};
    reset = 1'b0; ctrl_Mult_in = 1'b0; ctrl_Div_in = 1'b0; x_rd = '0;
    x_operandA = '0; x_operandB = '0; md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst stall", {31'd0, stall}, 0);
    chk("rst pulses", {30'd0, md_ctrl_Mult, md_ctrl_Div}, 0);
    chk("rst wb_valid", {31'd0, wb_valid}, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst operandA", md_operandA, 0);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) begin
      apply_vec(i);
      idle_check($sformatf("v%0d", i));
    end
    apply_vec(0);
    apply_vec(1);
    idle_check("b2b");
    @(negedge clk);
    ctrl_Mult_in = 1'b1; x_rd = 5'd4; x_operandA = 32'd11; x_operandB = 32'd13;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("midbusy stall_before_reset", {31'd0, stall}, 1);
    reset = 1'b0; ctrl_Mult_in = 1'b0;
    @(negedge clk);
    #1;
    chk("midbusy stall", {31'd0, stall}, 0);
    chk("midbusy operandA", md_operandA, 0);
    chk("midbusy operandB", md_operandB, 0);
    chk("midbusy wb_valid_in_reset", {31'd0, wb_valid}, 0);
    reset = 1'b1; md_resultRDY = 1'b1; md_result = 32'd77; md_exception = 1'b0;
    @(negedge clk);
    md_resultRDY = 1'b0;
    #1;
    chk("midbusy wb_valid", {31'd0, wb_valid}, 0);
    chk("midbusy wb_rd", {27'd0, wb_rd}, 0);
    chk("midbusy stall_after", {31'd0, stall}, 0);
    @(negedge clk);
    #1;
    chk("midbusy wb_valid_late", {31'd0, wb_valid}, 0);
    apply_vec(0);
    idle_check("post_reset");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
